// File: rtl/eth_rx_fcs_check.sv
// Ethernet RX FCS checker: CRC-32 residue check, 4-byte FCS strip, TLAST/TUSER framing.
// Optional frame statistics counters are enabled by defining ETH_RX_FCS_STATS_EN.
module eth_rx_fcs_check #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        CLK_125M,
  input  logic        SYS_RST,
  input  logic [7:0]  RGMII_RX_DATA,
  input  logic        RGMII_RX_VALID,
  input  logic        RGMII_RX_LAST,
  input  logic        RGMII_RX_USER,
  output logic        RGMII_RX_READY,
  output logic [7:0]  M_TDATA,
  output logic        M_TVALID,
  output logic        M_TLAST,
  output logic        M_TUSER,
  input  logic        M_TREADY
`ifdef ETH_RX_FCS_STATS_EN
  ,
  output logic [31:0] FRAME_OK_CNT,
  output logic [31:0] FRAME_ERR_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, LAST} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] LEN_SAT     = 11'(MAX_FRAME_LEN + 1);

  state_t          state_q, state_d;
  logic [3:0][7:0] hold_q, hold_d;
  logic [2:0]      hcnt_q, hcnt_d;
  logic [31:0]     crc_q, crc_d;
  logic [10:0]     len_q, len_d;
  logic            err_q, err_d;
  logic [7:0]      tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            tuser_q, tuser_d;
  logic            rdy_en_q;
`ifdef ETH_RX_FCS_STATS_EN
  logic [31:0]     ok_cnt_q, ok_cnt_d;
  logic [31:0]     err_cnt_q, err_cnt_d;
`endif

  logic        accept;
  logic        xfer;
  logic [31:0] crc_nxt;
  logic [10:0] len_nxt;
  logic        user_nxt;
  logic        frame_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Upstream ready follows the output register slot; the TLAST cycle blocks the next frame.
  assign xfer           = tvalid_q & M_TREADY;
  assign RGMII_RX_READY = rdy_en_q & (state_q != LAST) & (~tvalid_q | M_TREADY);
  assign accept         = RGMII_RX_VALID & RGMII_RX_READY;

  assign crc_nxt   = crc_byte(crc_q, RGMII_RX_DATA);
  assign len_nxt   = (len_q >= LEN_SAT) ? LEN_SAT : len_q + 11'd1;
  assign user_nxt  = err_q | RGMII_RX_USER;
  assign frame_bad = (crc_nxt != CRC_RESIDUE) | (len_nxt < LEN_MIN) | (len_nxt > LEN_MAX) | user_nxt;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hcnt_d   = hcnt_q;
    crc_d    = crc_q;
    len_d    = len_q;
    err_d    = err_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q & ~M_TREADY;
    tlast_d  = tlast_q & ~M_TREADY;
    tuser_d  = tuser_q & ~M_TREADY;
`ifdef ETH_RX_FCS_STATS_EN
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
`endif

    if (accept) begin
      crc_d  = crc_nxt;
      len_d  = len_nxt;
      err_d  = user_nxt;
      hold_d = {hold_q[2:0], RGMII_RX_DATA};
      if (hcnt_q != 3'd4) begin
        hcnt_d = hcnt_q + 3'd1;
      end

      if (RGMII_RX_LAST) begin
        if (hcnt_q == 3'd4) begin
          // The byte leaving the delay line is the final payload byte; the line now holds the FCS.
          tdata_d  = hold_q[3];
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tuser_d  = frame_bad;
          state_d  = LAST;
`ifdef ETH_RX_FCS_STATS_EN
          if (frame_bad) begin
            err_cnt_d = err_cnt_q + 32'd1;
          end else begin
            ok_cnt_d = ok_cnt_q + 32'd1;
          end
`endif
        end else begin
          // Runt of four bytes or fewer: nothing to forward, restart immediately.
          state_d = IDLE;
          hcnt_d  = 3'd0;
          crc_d   = CRC_INIT;
          len_d   = 11'd0;
          err_d   = 1'b0;
`ifdef ETH_RX_FCS_STATS_EN
          err_cnt_d = err_cnt_q + 32'd1;
`endif
        end
      end else if (hcnt_q == 3'd4) begin
        tdata_d  = hold_q[3];
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        state_d  = STREAM;
      end else begin
        state_d = (hcnt_q == 3'd3) ? STREAM : FILL;
      end
    end

    if ((state_q == LAST) && xfer) begin
      state_d = IDLE;
      hcnt_d  = 3'd0;
      crc_d   = CRC_INIT;
      len_d   = 11'd0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK_125M or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      hcnt_q   <= 3'd0;
      crc_q    <= CRC_INIT;
      len_q    <= 11'd0;
      err_q    <= 1'b0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      hcnt_q   <= hcnt_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef ETH_RX_FCS_STATS_EN
  always_ff @(posedge CLK_125M or posedge SYS_RST) begin
    if (SYS_RST) begin
      ok_cnt_q  <= 32'd0;
      err_cnt_q <= 32'd0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign FRAME_OK_CNT  = ok_cnt_q;
  assign FRAME_ERR_CNT = err_cnt_q;
`endif

  assign M_TDATA  = tdata_q;
  assign M_TVALID = tvalid_q;
  assign M_TLAST  = tlast_q;
  assign M_TUSER  = tuser_q;

endmodule
